// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache/memory arbiter: FSM state encodings,
// requester port indices and the burst-length helper.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TURN = 2'd2
    } arb_state_t;

    // Requester port indices into the grant vector
    localparam logic PORT_DCACHE = 1'b0;
    localparam logic PORT_ICACHE = 1'b1;

    // A zero burst length from memory still moves one beat
    function automatic logic [15:0] eff_burstlen(input logic [15:0] len);
        return (len == 16'd0) ? 16'd1 : len;
    endfunction

endpackage

// File: rtl/arb_req_latch.sv
// Sticky per-port request latch: remembers the first read/write request
// seen while the port is not being served, until the arbiter grants it.
module arb_req_latch #(
    parameter int ADDRBITS = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rdreq,
    input  logic                wrreq,
    input  logic [ADDRBITS-1:0] addr,
    input  logic                capture_en,
    input  logic                clear,
    output logic                pending,
    output logic                pend_rd,
    output logic [ADDRBITS-1:0] pend_addr
);

    logic take;

    // A new request is only taken when nothing is already held
    assign take = capture_en && (rdreq || wrreq) && !pending && !clear;

    // Pending flag and request type; clear (grant) has priority over capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            pend_rd <= 1'b0;
        end else if (clear) begin
            pending <= 1'b0;
        end else if (take) begin
            pending <= 1'b1;
            pend_rd <= rdreq;
        end
    end

    // Burst start address, only meaningful while the flag is set
    always_ff @(posedge clk) begin
        if (take) begin
            pend_addr <= addr;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Two-port (dcache / icache) arbiter in front of a single burst memory.
// Requests are latched, arbitrated round-robin, served as one burst, and
// followed by a single dead TURN cycle before the next arbitration.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDRBITS = 32,
    parameter int DATABITS = 32
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDRBITS-1:0] p0_addr,
    input  logic [DATABITS-1:0] p0_in,
    input  logic                p0_rdreq,
    input  logic                p0_wrreq,
    output logic [DATABITS-1:0] p0_out,
    output logic                p0_valid,
    output logic [15:0]         p0_burstlen,
    output logic                p0_grant,

    input  logic [ADDRBITS-1:0] p1_addr,
    input  logic [DATABITS-1:0] p1_in,
    input  logic                p1_rdreq,
    input  logic                p1_wrreq,
    output logic [DATABITS-1:0] p1_out,
    output logic                p1_valid,
    output logic [15:0]         p1_burstlen,
    output logic                p1_grant,

    output logic [ADDRBITS-1:0] mem_addr,
    output logic [DATABITS-1:0] mem_in,
    input  logic [DATABITS-1:0] mem_out,
    input  logic                mem_valid,
    input  logic [15:0]         mem_burstlen,
    output logic                mem_rdreq,
    output logic                mem_wrreq
);

    arb_state_t    state_q, state_nxt;
    logic [1:0]    grant_q, grant_nxt;
    logic          last_q, last_nxt;      // last granted port, 1 = icache
    logic [15:0]   cnt_q, cnt_nxt;
    logic [15:0]   len_q, len_nxt;
    logic          first_q, first_nxt;    // first BUSY cycle of a burst
    logic          rd_q, rd_nxt;          // current burst is a read
    logic          clr0, clr1;
    logic          sel;
    logic          beat;
    logic          gsel;

    logic                pend0, pend1;
    logic                pend_rd0, pend_rd1;
    logic [ADDRBITS-1:0] pend_addr0, pend_addr1;

    arb_req_latch #(.ADDRBITS(ADDRBITS)) u_latch0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .rdreq      (p0_rdreq),
        .wrreq      (p0_wrreq),
        .addr       (p0_addr),
        .capture_en (!((state_q == BUSY) && grant_q[PORT_DCACHE])),
        .clear      (clr0),
        .pending    (pend0),
        .pend_rd    (pend_rd0),
        .pend_addr  (pend_addr0)
    );

    arb_req_latch #(.ADDRBITS(ADDRBITS)) u_latch1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .rdreq      (p1_rdreq),
        .wrreq      (p1_wrreq),
        .addr       (p1_addr),
        .capture_en (!((state_q == BUSY) && grant_q[PORT_ICACHE])),
        .clear      (clr1),
        .pending    (pend1),
        .pend_rd    (pend_rd1),
        .pend_addr  (pend_addr1)
    );

    assign gsel = grant_q[PORT_ICACHE];

    // Reads advance on returned data, writes on each write strobe issued
    assign beat = (state_q == BUSY) && (rd_q ? mem_valid : mem_wrreq);

    // FSM and burst bookkeeping registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= PORT_ICACHE;
            cnt_q   <= 16'd0;
            len_q   <= 16'd1;
            first_q <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            grant_q <= grant_nxt;
            last_q  <= last_nxt;
            cnt_q   <= cnt_nxt;
            len_q   <= len_nxt;
            first_q <= first_nxt;
            rd_q    <= rd_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, count beats in BUSY, one dead cycle in TURN
    always_comb begin
        state_nxt = state_q;
        grant_nxt = grant_q;
        last_nxt  = last_q;
        cnt_nxt   = cnt_q;
        len_nxt   = len_q;
        first_nxt = 1'b0;
        rd_nxt    = rd_q;
        clr0      = 1'b0;
        clr1      = 1'b0;
        sel       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend0 || pend1) begin
                    // On a tie the port not served last goes first
                    sel       = (pend0 && pend1) ? ~last_q : pend1;
                    grant_nxt = sel ? 2'b10 : 2'b01;
                    last_nxt  = sel;
                    state_nxt = BUSY;
                    first_nxt = 1'b1;
                    cnt_nxt   = 16'd0;
                    len_nxt   = eff_burstlen(mem_burstlen);
                    rd_nxt    = sel ? pend_rd1 : pend_rd0;
                    clr0      = ~sel;
                    clr1      = sel;
                end
            end
            BUSY: begin
                if (beat) begin
                    if (cnt_q == len_q - 16'd1) begin
                        grant_nxt = 2'b00;
                        state_nxt = TURN;
                    end else begin
                        cnt_nxt = cnt_q + 16'd1;
                    end
                end
            end
            TURN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
            end
        endcase
    end

    // Memory-side mux: latched request on the first BUSY cycle, live port after
    always_comb begin
        mem_addr  = '0;
        mem_in    = '0;
        mem_rdreq = 1'b0;
        mem_wrreq = 1'b0;
        if (state_q == BUSY) begin
            mem_in = gsel ? p1_in : p0_in;
            if (first_q) begin
                mem_addr  = gsel ? pend_addr1 : pend_addr0;
                mem_rdreq = rd_q;
                mem_wrreq = ~rd_q;
            end else begin
                mem_addr  = gsel ? p1_addr : p0_addr;
                mem_rdreq = gsel ? p1_rdreq : p0_rdreq;
                mem_wrreq = gsel ? p1_wrreq : p0_wrreq;
            end
        end
    end

    assign p0_grant    = grant_q[PORT_DCACHE];
    assign p1_grant    = grant_q[PORT_ICACHE];
    assign p0_valid    = p0_grant && mem_valid && (state_q == BUSY);
    assign p1_valid    = p1_grant && mem_valid && (state_q == BUSY);
    assign p0_out      = mem_out;
    assign p1_out      = mem_out;
    assign p0_burstlen = mem_burstlen;
    assign p1_burstlen = mem_burstlen;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: stimulus pushes expected grant /
// read-beat / write-beat events, a negedge monitor pops and compares them.
module tb_cache_mem_arbiter;

    localparam int K_GRANT = 0;
    localparam int K_RBEAT = 1;
    localparam int K_WBEAT = 2;

    typedef struct {
        int          kind;
        bit          port;
        bit          rd;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] p0_addr, p0_in, p0_out, p1_addr, p1_in, p1_out;
    logic        p0_rdreq, p0_wrreq, p0_valid, p0_grant;
    logic        p1_rdreq, p1_wrreq, p1_valid, p1_grant;
    logic [15:0] p0_burstlen, p1_burstlen;
    logic [31:0] mem_addr, mem_in, mem_out;
    logic        mem_valid, mem_rdreq, mem_wrreq;
    logic [15:0] mem_burstlen;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic prev_g = 1'b0;

    cache_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .p0_addr(p0_addr), .p0_in(p0_in), .p0_rdreq(p0_rdreq), .p0_wrreq(p0_wrreq),
        .p0_out(p0_out), .p0_valid(p0_valid), .p0_burstlen(p0_burstlen), .p0_grant(p0_grant),
        .p1_addr(p1_addr), .p1_in(p1_in), .p1_rdreq(p1_rdreq), .p1_wrreq(p1_wrreq),
        .p1_out(p1_out), .p1_valid(p1_valid), .p1_burstlen(p1_burstlen), .p1_grant(p1_grant),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out), .mem_valid(mem_valid),
        .mem_burstlen(mem_burstlen), .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input bit port, input bit rd, input logic [31:0] val);
        exp_t e;
        e.kind = kind; e.port = port; e.rd = rd; e.val = val;
        q.push_back(e);
    endtask

    task automatic pop_exp(input int kind, output exp_t e, output bit ok);
        ok = 1'b0;
        e.kind = -1; e.port = 1'b0; e.rd = 1'b0; e.val = '0;
        if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d, expected no event", kind);
        end else begin
            e = q.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            ok = (e.kind == kind);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input bit port, input int bound);
        int n = 0;
        while (((port ? p1_grant : p0_grant) !== 1'b1) && n < bound) begin
            tick();
            n++;
        end
        if ((port ? p1_grant : p0_grant) !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_grant_p%0d: got no grant, expected grant within %0d cycles", port, bound);
        end
    endtask

    task automatic read_burst(input bit port, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            mem_valid = 1'b1;
            mem_out   = base + 32'(i);
            push(K_RBEAT, port, 1'b1, base + 32'(i));
            tick();
        end
        mem_valid = 1'b0;
    endtask

    // Monitor: pops one expected event per observed DUT output event
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (reset_n) begin
            chk("grant_onehot", 64'(p0_grant & p1_grant), 64'd0);
            if ((p0_grant || p1_grant) && !prev_g) begin
                pop_exp(K_GRANT, e, ok);
                if (ok) begin
                    chk("grant_port", 64'(p1_grant), 64'(e.port));
                    chk("grant_mem_addr", 64'(mem_addr), 64'(e.val));
                    chk("grant_mem_rdreq", 64'(mem_rdreq), 64'(e.rd));
                    chk("grant_mem_wrreq", 64'(mem_wrreq), 64'(!e.rd));
                end
            end
            if (p0_valid || p1_valid) begin
                pop_exp(K_RBEAT, e, ok);
                if (ok) begin
                    chk("rbeat_port", 64'(p1_valid), 64'(e.port));
                    chk("rbeat_data", 64'(p1_valid ? p1_out : p0_out), 64'(e.val));
                end
            end
            if (mem_wrreq) begin
                pop_exp(K_WBEAT, e, ok);
                if (ok) begin
                    chk("wbeat_port", 64'(p1_grant), 64'(e.port));
                    chk("wbeat_mem_in", 64'(mem_in), 64'(e.val));
                end
            end
        end
        prev_g <= p0_grant | p1_grant;
    end

    initial begin
        reset_n = 1'b0;
        p0_addr = '0; p0_in = '0; p0_rdreq = 1'b0; p0_wrreq = 1'b0;
        p1_addr = '0; p1_in = '0; p1_rdreq = 1'b0; p1_wrreq = 1'b0;
        mem_out = '0; mem_valid = 1'b1; mem_burstlen = 16'd4;
        repeat (2) tick();
        chk("rst_grant", 64'({p1_grant, p0_grant}), 64'd0);
        chk("rst_valid", 64'({p1_valid, p0_valid}), 64'd0);
        chk("rst_mem_req", 64'({mem_rdreq, mem_wrreq}), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        mem_valid = 1'b0;
        reset_n = 1'b1;
        tick();

        // Single 4-beat read from dcache
        p0_addr = 32'h100; p0_rdreq = 1'b1;
        push(K_GRANT, 1'b0, 1'b1, 32'h100);
        tick();
        p0_rdreq = 1'b0;
        wait_grant(1'b0, 8);
        chk("s1_burstlen_passthru", 64'(p0_burstlen), 64'd4);
        mem_valid = 1'b1; mem_out = 32'hD0;
        push(K_RBEAT, 1'b0, 1'b1, 32'hD0);
        tick();
        chk("s1_rdreq_one_cycle", 64'(mem_rdreq), 64'd0);
        read_burst(1'b0, 3, 32'hD1);
        chk("s1_grant_released", 64'(p0_grant), 64'd0);
        chk("s1_turn_mem_idle", 64'({mem_rdreq, mem_wrreq, mem_addr}), 64'd0);
        tick();

        // Tie after reset: dcache first, icache after one TURN cycle, next tie dcache
        reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        mem_burstlen = 16'd2;
        p0_addr = 32'h200; p1_addr = 32'h300; p0_rdreq = 1'b1; p1_rdreq = 1'b1;
        push(K_GRANT, 1'b0, 1'b1, 32'h200);
        tick();
        p0_rdreq = 1'b0; p1_rdreq = 1'b0;
        wait_grant(1'b0, 8);
        chk("s2_p1_waits", 64'(p1_grant), 64'd0);
        read_burst(1'b0, 2, 32'hE0);
        push(K_GRANT, 1'b1, 1'b1, 32'h300);
        tick();
        chk("s2_turn_gap", 64'(p1_grant), 64'd0);
        tick();
        chk("s2_p1_after_turn", 64'(p1_grant), 64'd1);
        read_burst(1'b1, 2, 32'hE8);
        tick();
        p0_addr = 32'h210; p1_addr = 32'h310; p0_rdreq = 1'b1; p1_rdreq = 1'b1;
        push(K_GRANT, 1'b0, 1'b1, 32'h210);
        tick();
        p0_rdreq = 1'b0; p1_rdreq = 1'b0;
        wait_grant(1'b0, 8);
        read_burst(1'b0, 2, 32'hF0);
        push(K_GRANT, 1'b1, 1'b1, 32'h310);
        wait_grant(1'b1, 8);
        read_burst(1'b1, 2, 32'hF8);
        tick();

        // 8-beat write from dcache, mem_in follows p0_in every beat
        mem_burstlen = 16'd8;
        p0_addr = 32'h500; p0_in = 32'hA0; p0_wrreq = 1'b1;
        push(K_GRANT, 1'b0, 1'b0, 32'h500);
        tick();
        wait_grant(1'b0, 8);
        for (int i = 0; i < 8; i++) begin
            p0_in = 32'hA0 + 32'(i);
            push(K_WBEAT, 1'b0, 1'b0, 32'hA0 + 32'(i));
            if (i == 7) chk("s3_grant_held_to_last", 64'(p0_grant), 64'd1);
            tick();
        end
        p0_wrreq = 1'b0;
        chk("s3_grant_released", 64'(p0_grant), 64'd0);
        chk("s3_turn_wrreq", 64'(mem_wrreq), 64'd0);
        tick();

        // icache request during dcache burst keeps its first address
        mem_burstlen = 16'd4;
        p0_addr = 32'h600; p0_rdreq = 1'b1;
        push(K_GRANT, 1'b0, 1'b1, 32'h600);
        tick();
        p0_rdreq = 1'b0;
        wait_grant(1'b0, 8);
        p1_addr = 32'h40; p1_rdreq = 1'b1;
        tick();
        p1_rdreq = 1'b0; p1_addr = 32'h80;
        read_burst(1'b0, 4, 32'h60);
        push(K_GRANT, 1'b1, 1'b1, 32'h40);
        wait_grant(1'b1, 8);
        read_burst(1'b1, 4, 32'h70);
        tick();

        // Reset mid-burst after 2 of 4 beats, with icache pending
        p0_addr = 32'h700; p0_rdreq = 1'b1;
        push(K_GRANT, 1'b0, 1'b1, 32'h700);
        tick();
        p0_rdreq = 1'b0;
        wait_grant(1'b0, 8);
        mem_valid = 1'b1; mem_out = 32'h11;
        push(K_RBEAT, 1'b0, 1'b1, 32'h11);
        p1_rdreq = 1'b1; p1_addr = 32'h900;
        tick();
        p1_rdreq = 1'b0; mem_out = 32'h12;
        push(K_RBEAT, 1'b0, 1'b1, 32'h12);
        tick();
        mem_out = 32'h13;
        #1 reset_n = 1'b0;
        #1;
        chk("s5_rst_grant", 64'({p1_grant, p0_grant}), 64'd0);
        chk("s5_rst_valid", 64'({p1_valid, p0_valid}), 64'd0);
        chk("s5_rst_mem_req", 64'({mem_rdreq, mem_wrreq}), 64'd0);
        chk("s5_rst_mem_addr_in", 64'({mem_addr, mem_in}), 64'd0);
        mem_valid = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        repeat (4) tick();
        chk("s5_pending_cleared", 64'({p1_grant, p0_grant}), 64'd0);
        p1_addr = 32'h900; p1_rdreq = 1'b1;
        push(K_GRANT, 1'b1, 1'b1, 32'h900);
        tick();
        p1_rdreq = 1'b0;
        wait_grant(1'b1, 8);
        read_burst(1'b1, 4, 32'h90);
        tick();

        // mem_valid in IDLE is ignored; zero burst length means one beat
        mem_valid = 1'b1; mem_out = 32'hBAD;
        tick();
        chk("s6_idle_valid", 64'({p1_valid, p0_valid}), 64'd0);
        tick();
        mem_valid = 1'b0;
        mem_burstlen = 16'd0;
        p0_addr = 32'hA00; p0_rdreq = 1'b1;
        push(K_GRANT, 1'b0, 1'b1, 32'hA00);
        tick();
        p0_rdreq = 1'b0;
        wait_grant(1'b0, 8);
        read_burst(1'b0, 1, 32'hC0);
        chk("s6_len0_single_beat", 64'(p0_grant), 64'd0);
        tick(); tick();

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of run, expected finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDRBITS, default 32, memory address width.
REQ-002 SHALL have parameter DATABITS, default 32, memory data width.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  input  1  clock, rising-edge; reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have, per requester port pN (N=0 dcache, N=1 icache), pN_addr  input  ADDRBITS  burst start address.
REQ-005 SHALL have pN_in  input  DATABITS  write data.
REQ-006 SHALL have pN_rdreq  input  1  read-burst request.
REQ-007 SHALL have pN_wrreq  input  1  write-burst request.
REQ-008 SHALL have pN_out  output  DATABITS  read data, equal to mem_out.
REQ-009 SHALL have pN_valid  output  1  mem_valid gated by grant.
REQ-010 SHALL have pN_burstlen  output  16  equal to mem_burstlen.
REQ-011 SHALL have pN_grant  output  1  port owns memory.
REQ-012 SHALL have the memory side: mem_addr  output  ADDRBITS; mem_in  output  DATABITS; mem_out  input  DATABITS; mem_valid  input  1; mem_burstlen  input  16; mem_rdreq  output  1; mem_wrreq  output  1.

Function
REQ-013 SHALL implement the states IDLE, BUSY and TURN, encoded 2 bits.
REQ-014 SHALL keep a sticky pending bit, type (rd/wr) and address per port: set on any cycle pN_rdreq|pN_wrreq is high and the port is not granted in BUSY; if already set, the new request is ignored; rdreq wins if both are asserted.
REQ-015 SHALL, in IDLE with any pending bit, register grant next cycle and enter BUSY; if both are pending, grant the port not granted last; the last-granted pointer resets to port1, so port0 wins the first tie.
REQ-016 SHALL, on the grant edge, clear the granted pending bit, latch burstlen = mem_burstlen (0 treated as 1), and clear the beat counter (16 bits).
REQ-017 SHALL, in the first BUSY cycle, drive mem_addr and the latched request type on mem_rdreq/mem_wrreq from the pending latch, for exactly one cycle.
REQ-018 SHALL, in later BUSY cycles, pass mem_addr, mem_in, mem_rdreq and mem_wrreq combinationally from the granted port.
REQ-019 SHALL count a beat on mem_valid for a read burst and on mem_wrreq high for a write burst.
REQ-020 SHALL, when the counter equals latched burstlen-1 and a beat occurs, drop the grant and enter TURN.
REQ-021 SHALL hold TURN for exactly 1 cycle with all mem_* outputs 0, then enter IDLE.
REQ-022 SHALL capture a request in TURN into pending; the ex-owner re-asserting per burst therefore re-arbitrates.
REQ-023 SHALL drive mem_addr, mem_in, mem_rdreq and mem_wrreq to 0 in IDLE and TURN.
REQ-024 SHALL assert pN_valid only while pN_grant=1 and mem_valid=1; mem_valid outside BUSY is ignored and not counted.
REQ-025 SHALL ignore requester activity on the non-granted port except for pending capture.
REQ-026 SHALL keep grant one-hot or zero at all times.

Reset
REQ-027 SHALL, on reset_n low at any time including mid-burst, immediately set: state IDLE, grants 0, pending bits 0, counter 0, pointer port1, and all mem_* and pN_valid outputs 0.
REQ-028 SHALL NOT flush or complete an in-flight burst on reset; the requester restarts it.

Structure
REQ-029 SHALL place the state encodings (IDLE/BUSY/TURN) and the port index constants in the shared cache package.
REQ-030 SHALL implement the per-port pending latch as one sub-module, arb_req_latch, instantiated twice; the FSM and the output mux stay in cache_mem_arbiter.

Verification
REQ-031 SHALL cover: p0_rdreq 1 cycle, addr 0x100, mem_burstlen=4 -> p0_grant next cycle, mem_rdreq=1 for 1 cycle with mem_addr=0x100, 4 mem_valid beats routed to p0_valid, TURN 1 cycle, IDLE.
REQ-032 SHALL cover: p0_rdreq and p1_rdreq same cycle after reset -> p0 granted first; p1 granted after p0 burst plus 1 TURN cycle; next tie -> p0.
REQ-033 SHALL cover: p0_wrreq, burstlen=8, mem_wrreq held by p0 for 8 cycles -> grant released after the 8th cycle, mem_in tracks p0_in each beat.
REQ-034 SHALL cover: p1_rdreq during p0 BUSY, p1_addr=0x40 then changed to 0x80 -> p1 granted later with mem_addr=0x40.
REQ-035 SHALL cover: reset_n low after 2 of 4 beats -> all outputs 0 same cycle, pending cleared; a new request after release is granted normally.
REQ-036 SHALL cover: mem_burstlen=0 -> burst ends after 1 beat; mem_valid in IDLE -> no pN_valid.
